bisc_mvm_sequencer: RTL and testbench

BISC_MVM_SEQUENCER -- requirements
Module: bisc_mvm_sequencer

---
 rtl/bisc_mvm_sequencer.sv | 131 +++++++++++++
 tb/tb_bisc_mvm_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bisc_mvm_sequencer.sv
// Pass sequencer for the bit-serial stochastic matrix-vector multiplier.
// A job is a number of passes. Each pass clears the selector and the accumulators,
// streams SC_LEN selector-enable cycles, then presents the pass result until it is taken.
// Selector/sequencer count disagreement is latched into a sticky error flag.
module bisc_mvm_sequencer #(
  parameter int unsigned SC_LEN = 256,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PASS_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  input  logic [PASS_W-1:0] num_passes,
  output logic              start_ready,
  input  logic              hold,
  input  logic              abort,
  input  logic              zero_select,
  output logic              sel_enable,
  output logic              sel_reset,
  output logic              acc_clear,
  output logic              pass_valid,
  input  logic              pass_ready,
  output logic [PASS_W-1:0] pass_idx,
  output logic              done,
  output logic              busy,
  output logic              sync_err
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SC_LEN - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PASS_W-1:0] num_q;
  logic [PASS_W-1:0] idx_q;
  logic              err_q;

  logic run_en;
  logic cnt_last;
  logic pass_last;
  logic abort_act;

  // Shared decode of the current state against the live inputs.
  always_comb begin
    run_en    = (state_q == StRun) & ~hold;
    cnt_last  = (cnt_q == CntLast);
    // num_q is never 0 while draining, so num_q-1 cannot wrap here.
    pass_last = (idx_q == (num_q - PASS_W'(1)));
    // Abort only acts on a live job; in idle it is ignored so it cannot block an accept.
    abort_act = abort & (state_q != StIdle);
  end

  // State, bit counter, pass bookkeeping and sticky sync error.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (abort_act) begin
      // Abort wins over hold, handshake and counter terminal; the error flag survives it.
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            num_q   <= num_passes;
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= (num_passes == '0) ? StDone : StClear;
          end
        end
        StClear: begin
          cnt_q   <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (!hold) begin
            // Counter wraps to 0 naturally after SC_LEN-1 since CNT_W = log2(SC_LEN).
            cnt_q <= cnt_q + CNT_W'(1);
            if (zero_select != cnt_last) begin
              err_q <= 1'b1;
            end
            if (cnt_last) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pass_ready) begin
            if (pass_last) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + PASS_W'(1);
              state_q <= StClear;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode; reset forces everything low except the selector clear.
  always_comb begin
    start_ready = reset & (state_q == StIdle);
    sel_enable  = reset & run_en;
    sel_reset   = ~reset | (state_q == StClear) | abort_act;
    acc_clear   = reset & (state_q == StClear);
    pass_valid  = reset & (state_q == StDrain);
    done        = reset & (state_q == StDone) & ~abort;
    busy        = reset & (state_q != StIdle);
    pass_idx    = reset ? idx_q : '0;
    sync_err    = reset & err_q;
  end

endmodule

// File: tb/tb_bisc_mvm_sequencer.sv
// Bench for bisc_mvm_sequencer: a job-level behavioural walk that drives random
// hold / pass_ready / abort / reset and predicts every output cycle by cycle.
module tb_bisc_mvm_sequencer;

  localparam int unsigned ScLen = 16;
  localparam int unsigned CntW  = 4;
  localparam int unsigned PassW = 4;

  // Output vector order: start_ready sel_enable sel_reset acc_clear pass_valid done busy
  localparam logic [6:0] OIdle  = 7'b1000000;
  localparam logic [6:0] OClear = 7'b0011001;
  localparam logic [6:0] ORun   = 7'b0100001;
  localparam logic [6:0] OHold  = 7'b0000001;
  localparam logic [6:0] ODrain = 7'b0000101;
  localparam logic [6:0] ODone  = 7'b0000011;
  localparam logic [6:0] OReset = 7'b0010000;
  localparam logic [6:0] SelRst = 7'b0010000;
  localparam logic [6:0] DoneB  = 7'b0000010;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start_valid = 1'b0;
  logic [PassW-1:0] num_passes = '0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic             zero_select = 1'b0;
  logic             pass_ready = 1'b0;
  logic             start_ready, sel_enable, sel_reset, acc_clear, pass_valid, done, busy;
  logic             sync_err;
  logic [PassW-1:0] pass_idx;

  wire [6:0] outs = {start_ready, sel_enable, sel_reset, acc_clear, pass_valid, done, busy};

  int   n_chk = 0;
  int   n_pass = 0;
  int   jt = 0;
  int   abort_at = -1;
  int   reset_at = -1;
  logic err_exp = 1'b0;

  bisc_mvm_sequencer #(
    .SC_LEN (ScLen),
    .CNT_W  (CntW),
    .PASS_W (PassW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .num_passes  (num_passes),
    .start_ready (start_ready),
    .hold        (hold),
    .abort       (abort),
    .zero_select (zero_select),
    .sel_enable  (sel_enable),
    .sel_reset   (sel_reset),
    .acc_clear   (acc_clear),
    .pass_valid  (pass_valid),
    .pass_ready  (pass_ready),
    .pass_idx    (pass_idx),
    .done        (done),
    .busy        (busy),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One job cycle: apply abort/reset if scheduled, check outputs, advance to the next negedge.
  task automatic step(input string tag, input logic [6:0] base, input int idx_exp,
                      output logic stop);
    logic ab;
    logic rs;
    ab    = (jt == abort_at);
    rs    = (jt == reset_at);
    abort = ab;
    if (rs) reset = 1'b0;
    #1;
    if (rs) begin
      check({tag, "_rst"}, 32'(outs), 32'(OReset));
      check({tag, "_rst_idx"}, 32'(pass_idx), 32'(0));
      check({tag, "_rst_err"}, 32'(sync_err), 32'(0));
    end else begin
      check(tag, 32'(outs), 32'(ab ? ((base | SelRst) & ~DoneB) : base));
      if (idx_exp >= 0) check({tag, "_idx"}, 32'(pass_idx), 32'(idx_exp));
      check({tag, "_err"}, 32'(sync_err), 32'(err_exp));
    end
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    reset = 1'b1;
    if (rs) err_exp = 1'b0;
    jt++;
    stop = ab | rs;
  endtask

  task automatic noise();
    start_valid = 1'($urandom_range(0, 1));
    hold        = 1'($urandom_range(0, 1));
    pass_ready  = 1'($urandom_range(0, 1));
    zero_select = 1'($urandom_range(0, 1));
  endtask

  // Walk one job as the selector/downstream would see it.
  task automatic run_job(input int np, input int hold_pct, input int rdy_pct, input int rdy_delay,
                         input int hold_at, input int err_at, input int ab_at, input int rs_at,
                         input string name);
    logic stop;
    int   k;
    int   en_cnt;
    int   run_cyc;
    int   drain_cyc;
    int   hcnt;
    logic zs_exp;
    start_valid = 1'b1;
    num_passes  = PassW'(np);
    abort       = 1'($urandom_range(0, 1));
    hold        = 1'($urandom_range(0, 1));
    pass_ready  = 1'($urandom_range(0, 1));
    zero_select = 1'($urandom_range(0, 1));
    #1;
    check({name, "_accept"}, 32'(outs), 32'(OIdle));
    check({name, "_accept_err"}, 32'(sync_err), 32'(err_exp));
    @(posedge clock);
    @(negedge clock);
    start_valid = 1'b0;
    abort       = 1'b0;
    err_exp     = 1'b0;
    jt          = 0;
    abort_at    = ab_at;
    reset_at    = rs_at;
    en_cnt      = 0;
    for (int p = 0; p < np; p++) begin
      noise();
      step({name, "_clear"}, OClear, p, stop);
      if (stop) return;
      k       = 0;
      run_cyc = 0;
      hcnt    = 0;
      while (k < int'(ScLen)) begin
        if (p == 0 && k == hold_at && hcnt < 10) begin
          hold = 1'b1;
          hcnt++;
        end else begin
          hold = (run_cyc < 4 * int'(ScLen)) && (int'($urandom_range(0, 99)) < hold_pct);
        end
        zs_exp      = (k == int'(ScLen) - 1);
        zero_select = zs_exp ^ (!hold && en_cnt == err_at);
        start_valid = 1'($urandom_range(0, 1));
        pass_ready  = 1'($urandom_range(0, 1));
        step({name, "_run"}, hold ? OHold : ORun, p, stop);
        if (stop) return;
        run_cyc++;
        if (!hold) begin
          if (zero_select != zs_exp) err_exp = 1'b1;
          k++;
          en_cnt++;
        end
      end
      if (p == 0 && hold_at >= 0 && hold_pct == 0) begin
        check({name, "_run_len"}, 32'(run_cyc), 32'(ScLen + 10));
      end
      drain_cyc = 0;
      do begin
        noise();
        pass_ready = (drain_cyc >= 40) ||
                     ((drain_cyc >= rdy_delay) && (int'($urandom_range(0, 99)) < rdy_pct));
        step({name, "_drain"}, ODrain, p, stop);
        if (stop) return;
        drain_cyc++;
      end while (!pass_ready);
      if (rdy_delay > 0 && rdy_pct == 100) begin
        check({name, "_drain_len"}, 32'(drain_cyc), 32'(rdy_delay + 1));
      end
    end
    noise();
    start_valid = 1'b0;
    step({name, "_done"}, ODone, -1, stop);
    if (stop) return;
    if (hold_pct == 0 && hold_at < 0 && rdy_pct == 100 && rdy_delay == 0) begin
      check({name, "_job_len"}, 32'(jt), 32'(np * int'(ScLen + 2) + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("por_outs", 32'(outs), 32'(OReset));
    check("por_idx", 32'(pass_idx), 32'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("idle_outs", 32'(outs), 32'(OIdle));
    check("idle_idx", 32'(pass_idx), 32'(0));
    check("idle_err", 32'(sync_err), 32'(0));

    run_job(2, 0, 100, 0, -1, -1, -1, -1, "basic");
    run_job(1, 0, 100, 0, 5, -1, -1, -1, "hold");
    run_job(2, 0, 100, 5, -1, -1, -1, -1, "drainwait");
    run_job(0, 0, 100, 0, -1, -1, -1, -1, "zero");
    run_job(2, 0, 100, 0, -1, 3, -1, -1, "syncerr");
    run_job(1, 0, 100, 0, -1, -1, -1, -1, "errclr");
    // Pass 0 occupies jt 0..ScLen+1; pass 1 clear at ScLen+2, counter 8 at ScLen+11.
    run_job(2, 0, 100, 0, -1, -1, int'(ScLen) + 11, -1, "abort");
    run_job(3, 0, 100, 0, -1, -1, -1, 10, "rstrun");
    run_job(int'((1 << PassW) - 1), 20, 70, 0, -1, -1, -1, -1, "maxpass");

    for (int j = 0; j < 25; j++) begin
      int np;
      int sel;
      np  = int'($urandom_range(0, 4));
      sel = int'($urandom_range(0, 3));
      run_job(np, int'($urandom_range(0, 40)), int'($urandom_range(30, 100)),
              int'($urandom_range(0, 3)), -1,
              (sel == 0) ? int'($urandom_range(0, 40)) : -1,
              (sel == 1) ? int'($urandom_range(0, 80)) : -1,
              (sel == 2) ? int'($urandom_range(0, 80)) : -1, "rnd");
    end

    start_valid = 1'b0;
    #1;
    check("final_idle", 32'(outs), 32'(OIdle));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
